sync_ising_matrix: RTL and testbench

//  Clocked, parametrised successor to the free-running coupled-oscillator array.

---
 rtl/sync_ising_matrix.sv | 162 ++++++++++++++++
 tb/tb_sync_ising_matrix.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_ising_matrix.sv
// sync_ising_matrix: clocked array of N phase-accumulator spins coupled through
// runtime-programmable symmetric weights. A run loads initial spins into the
// phase MSBs, advances every accumulator once per cycle for run_cycles cycles
// at a rate set by its local field, then samples the spin values.
//
// Control is a level-sampled strobe interface (no valid/ready handshake):
// start, stop and wr_en are sampled on every rising clk edge. start is acted
// on only in IDLE, wr_en only in IDLE with an in-range address, and stop only
// in IDLE (suppressing a same-cycle start) or RUN (abort).
module sync_ising_matrix #(
    parameter int N           = 3,
    parameter int NUM_WEIGHTS = 5,
    parameter int PHASE_BITS  = 4,
    parameter int CYC_W       = 16,
    localparam int WW         = $clog2(NUM_WEIGHTS),
    localparam int NP         = N * (N - 1) / 2,
    localparam int AW         = (NP > 1) ? $clog2(NP) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WW-1:0]           wr_data,
    input  logic                    start,
    input  logic                    stop,
    input  logic [CYC_W-1:0]        run_cycles,
    input  logic [N-1:0]            init_spins,
    output logic                    busy,
    output logic                    done,
    output logic [N-1:0]            spins_out,
    output logic [N*PHASE_BITS-1:0] phase_out
);

    localparam int MID = (NUM_WEIGHTS - 1) / 2;
    // Field magnitude is at most (N-1)*MID < N*2^WW, plus sign and margin.
    localparam int HW  = WW + $clog2(N) + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [CYC_W-1:0]       cnt_q, cnt_d;
    logic [WW-1:0]          w_q [NP];
    logic [PHASE_BITS-1:0]  phase_q [N];
    logic [PHASE_BITS-1:0]  phase_d [N];
    logic [PHASE_BITS-1:0]  step_c [N];
    logic signed [HW-1:0]   field_c [N];
    logic signed [HW-1:0]   align_c [N];
    logic [N-1:0]           msb_c;
    logic [N-1:0]           spins_q, spins_d;
    logic                   done_q, done_d;
    logic                   wr_ok;

    // Upper-triangle pair index for a < b.
    function automatic int pair_idx(input int a, input int b);
        return N * a - a * (a + 1) / 2 + b - a - 1;
    endfunction

    // Signed coupling strength encoded by a weight code (MID means zero).
    function automatic logic signed [HW-1:0] coupling(input logic [WW-1:0] code);
        return $signed({{(HW - WW){1'b0}}, code}) - $signed(HW'(MID));
    endfunction

    // Local field per spin and the resulting phase step (+3 anti-aligned, +2 zero, +1 aligned).
    always_comb begin
        for (int i = 0; i < N; i++) begin
            msb_c[i]   = phase_q[i][PHASE_BITS-1];
            field_c[i] = '0;
            for (int j = 0; j < N; j++) begin
                if (j != i) begin
                    if (phase_q[j][PHASE_BITS-1])
                        field_c[i] = field_c[i]
                                   + coupling(w_q[AW'(pair_idx((i < j) ? i : j, (i < j) ? j : i))]);
                    else
                        field_c[i] = field_c[i]
                                   - coupling(w_q[AW'(pair_idx((i < j) ? i : j, (i < j) ? j : i))]);
                end
            end
            align_c[i] = phase_q[i][PHASE_BITS-1] ? field_c[i] : -field_c[i];
            if (align_c[i] < 0)
                step_c[i] = PHASE_BITS'(3);
            else if (align_c[i] == 0)
                step_c[i] = PHASE_BITS'(2);
            else
                step_c[i] = PHASE_BITS'(1);
        end
    end

    assign wr_ok = (state_q == S_IDLE) && wr_en && ({1'b0, wr_addr} < (AW + 1)'(NP));

    // Weight storage: writable only while idle, reset to zero coupling.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NP; k++) w_q[k] <= WW'(MID);
        end else if (wr_ok) begin
            w_q[wr_addr] <= wr_data;
        end
    end

    // Run FSM next-state: load on start, step while running, sample on completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        spins_d = spins_q;
        for (int i = 0; i < N; i++) phase_d[i] = phase_q[i];
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    cnt_d = run_cycles;
                    for (int i = 0; i < N; i++)
                        phase_d[i] = {init_spins[i], {(PHASE_BITS - 1){1'b0}}};
                    state_d = (run_cycles == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    for (int i = 0; i < N; i++) phase_d[i] = phase_q[i] + step_c[i];
                    cnt_d = cnt_q - CYC_W'(1);
                    if (cnt_q == CYC_W'(1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                spins_d = msb_c;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Run FSM and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            spins_q <= '0;
            for (int i = 0; i < N; i++) phase_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            spins_q <= spins_d;
            for (int i = 0; i < N; i++) phase_q[i] <= phase_d[i];
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign spins_out = spins_q;

    // Pack live phases, spin i in slice i.
    always_comb begin
        phase_out = '0;
        for (int i = 0; i < N; i++) phase_out[i*PHASE_BITS +: PHASE_BITS] = phase_q[i];
    end

endmodule

// File: tb/tb_sync_ising_matrix.sv
// tb_sync_ising_matrix: scenario tests and randomized runs for sync_ising_matrix
// (N=3, NUM_WEIGHTS=5, PHASE_BITS=4) against an integer reference model.
module tb_sync_ising_matrix;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [2:0]  wr_data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] run_cycles = '0;
    logic [2:0]  init_spins = '0;
    logic        busy;
    logic        done;
    logic [2:0]  spins_out;
    logic [11:0] phase_out;

    int checks = 0;
    int failures = 0;

    // Reference model state: weight codes, phases, sampled spins.
    int          mw [3];
    int          mph [3];
    logic [2:0]  msp;

    sync_ising_matrix #(
        .N(3), .NUM_WEIGHTS(5), .PHASE_BITS(4), .CYC_W(16)
    ) dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .run_cycles(run_cycles), .init_spins(init_spins),
        .busy(busy), .done(done), .spins_out(spins_out), .phase_out(phase_out)
    );

    // Clock
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int pidx(input int a, input int b);
        return 3 * a - a * (a + 1) / 2 + b - a - 1;
    endfunction

    function automatic int cpl(input int a, input int b);
        return (a < b) ? mw[pidx(a, b)] - 2 : mw[pidx(b, a)] - 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin mw[i] = 2; mph[i] = 0; end
        msp = 3'b000;
    endtask

    // Load initial spins then apply r synchronous Ising-style updates.
    task automatic model_run(input int r, input logic [2:0] init);
        int sig [3];
        int nph [3];
        int h, p;
        for (int i = 0; i < 3; i++) mph[i] = init[i] ? 8 : 0;
        for (int s = 0; s < r; s++) begin
            for (int i = 0; i < 3; i++) sig[i] = (mph[i] >= 8) ? 1 : -1;
            for (int i = 0; i < 3; i++) begin
                h = 0;
                for (int j = 0; j < 3; j++) if (j != i) h += cpl(i, j) * sig[j];
                p = sig[i] * h;
                nph[i] = (mph[i] + ((p < 0) ? 3 : (p == 0) ? 2 : 1)) % 16;
            end
            for (int i = 0; i < 3; i++) mph[i] = nph[i];
        end
    endtask

    function automatic logic [2:0] model_spins();
        logic [2:0] s;
        for (int i = 0; i < 3; i++) s[i] = (mph[i] >= 8);
        return s;
    endfunction

    function automatic logic [11:0] model_phases();
        logic [11:0] v;
        for (int i = 0; i < 3; i++) v[i*4 +: 4] = 4'(mph[i]);
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic write_w(input int a, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 2'(a); wr_data = 3'(d);
        @(negedge clk);
        wr_en = 1'b0;
        if (a < 3) mw[a] = d;
    endtask

    // mode 0: no write, 1: write together with start, 2: write in the first run cycles.
    // hold keeps start asserted while the run is busy. lat counts negedges after the start
    // edge until done is seen (-1 if never); bcnt counts negedges with busy high.
    task automatic do_run(input int r, input logic [2:0] init, input int mode,
                          input int wa, input int wd, input bit hold,
                          output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; run_cycles = 16'(r); init_spins = init;
        if (mode == 1) begin wr_en = 1'b1; wr_addr = 2'(wa); wr_data = 3'(wd); end
        @(posedge clk);
        #1;
        start = hold; wr_en = 1'b0;
        lat = -1; bcnt = 0;
        for (int n = 1; n <= r + 10; n++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin lat = n; break; end
            start   = hold && (n <= r);
            wr_en   = (mode == 2) && (n <= 2);
            wr_addr = 2'(wa);
            wr_data = 3'(wd);
        end
        start = 1'b0; wr_en = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        model_reset();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (spins_out !== 3'b000) begin failures++; $display("FAIL reset_spins got=%b exp=000", spins_out); end
        checks++; if (phase_out !== 12'h000) begin failures++; $display("FAIL reset_phase got=%h exp=000", phase_out); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_default_run(input string tag);
        int lat, bcnt;
        logic [11:0] ph;
        do_run(4, 3'b000, 0, 0, 0, 1'b0, lat, bcnt);
        model_run(4, 3'b000);
        msp = model_spins();
        checks++; if (lat != 6) begin failures++; $display("FAIL %s_latency got=%0d exp=6", tag, lat); end
        checks++; if (bcnt != 4) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=4", tag, bcnt); end
        checks++; if (phase_out !== 12'h888) begin failures++; $display("FAIL %s_phase got=%h exp=888", tag, phase_out); end
        checks++; if (spins_out !== 3'b111) begin failures++; $display("FAIL %s_spins got=%b exp=111", tag, spins_out); end
        ph = model_phases();
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s_done_width got=%b exp=0", tag, done); end
        repeat (3) @(negedge clk);
        checks++; if (phase_out !== ph) begin failures++; $display("FAIL %s_idle_hold got=%h exp=%h", tag, phase_out, ph); end
    endtask

    task automatic test_all_plus2();
        int lat, bcnt;
        for (int a = 0; a < 3; a++) write_w(a, 4);
        do_run(1, 3'b011, 0, 0, 0, 1'b0, lat, bcnt);
        model_run(1, 3'b011);
        msp = model_spins();
        checks++; if (lat != 3) begin failures++; $display("FAIL plus2_latency got=%0d exp=3", lat); end
        checks++; if (phase_out !== 12'h3AA) begin failures++; $display("FAIL plus2_phase got=%h exp=3aa", phase_out); end
        checks++; if (spins_out !== 3'b011) begin failures++; $display("FAIL plus2_spins got=%b exp=011", spins_out); end
        checks++; if (phase_out !== model_phases()) begin failures++; $display("FAIL plus2_model got=%h exp=%h", phase_out, model_phases()); end
    endtask

    task automatic test_write_ignored();
        int lat, bcnt;
        logic [2:0] init;
        init = 3'($urandom_range(0, 7));
        // Write attempted during RUN (with start also held): no effect.
        do_run(6, init, 2, 1, 0, 1'b1, lat, bcnt);
        model_run(6, init);
        msp = model_spins();
        checks++; if (lat != 8) begin failures++; $display("FAIL run_write_latency got=%0d exp=8", lat); end
        checks++; if (bcnt != 6) begin failures++; $display("FAIL run_write_busy got=%0d exp=6", bcnt); end
        checks++; if (phase_out !== model_phases()) begin failures++; $display("FAIL run_write_phase got=%h exp=%h", phase_out, model_phases()); end
        // Rerun to observe the stored weights, then an out-of-range write and another rerun.
        do_run(6, init, 0, 0, 0, 1'b0, lat, bcnt);
        checks++; if (phase_out !== model_phases()) begin failures++; $display("FAIL run_write_readback got=%h exp=%h", phase_out, model_phases()); end
        write_w(3, 0);
        do_run(6, init, 0, 0, 0, 1'b0, lat, bcnt);
        checks++; if (phase_out !== model_phases()) begin failures++; $display("FAIL oor_write_phase got=%h exp=%h", phase_out, model_phases()); end
        checks++; if (spins_out !== msp) begin failures++; $display("FAIL oor_write_spins got=%b exp=%b", spins_out, msp); end
    endtask

    task automatic test_write_with_start();
        int lat, bcnt;
        logic [2:0] init;
        init = 3'b001;
        mw[1] = 0;
        do_run(3, init, 1, 1, 0, 1'b0, lat, bcnt);
        model_run(3, init);
        msp = model_spins();
        checks++; if (phase_out !== model_phases()) begin failures++; $display("FAIL wr_start_phase got=%h exp=%h", phase_out, model_phases()); end
        checks++; if (spins_out !== msp) begin failures++; $display("FAIL wr_start_spins got=%b exp=%b", spins_out, msp); end
    endtask

    task automatic test_stop();
        logic [2:0] init;
        int dcnt;
        init = 3'($urandom_range(0, 7));
        @(negedge clk);
        start = 1'b1; run_cycles = 16'd10; init_spins = init;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stop_busy_before got=%b exp=1", busy); end
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        model_run(1, init);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_busy_after got=%b exp=0", busy); end
        checks++; if (phase_out !== model_phases()) begin failures++; $display("FAIL stop_phase got=%h exp=%h", phase_out, model_phases()); end
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        checks++; if (dcnt != 0) begin failures++; $display("FAIL stop_no_done got=%0d exp=0", dcnt); end
        checks++; if (spins_out !== msp) begin failures++; $display("FAIL stop_spins_kept got=%b exp=%b", spins_out, msp); end
        checks++; if (phase_out !== model_phases()) begin failures++; $display("FAIL stop_phase_hold got=%h exp=%h", phase_out, model_phases()); end
        // start and stop together in IDLE: no effect.
        @(negedge clk);
        start = 1'b1; stop = 1'b1; run_cycles = 16'd3; init_spins = ~init;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || phase_out !== model_phases()) begin
            failures++; $display("FAIL start_stop_idle busy=%b phase=%h exp busy=0 phase=%h", busy, phase_out, model_phases());
        end
    endtask

    task automatic test_r0();
        int lat, bcnt;
        logic [2:0] init;
        init = 3'($urandom_range(1, 6));
        do_run(0, init, 0, 0, 0, 1'b0, lat, bcnt);
        model_run(0, init);
        msp = model_spins();
        checks++; if (lat != 2) begin failures++; $display("FAIL r0_latency got=%0d exp=2", lat); end
        checks++; if (bcnt != 0) begin failures++; $display("FAIL r0_busy got=%0d exp=0", bcnt); end
        checks++; if (spins_out !== init) begin failures++; $display("FAIL r0_spins got=%b exp=%b", spins_out, init); end
    endtask

    task automatic test_random();
        int lat, bcnt, r, mode, wa, wd;
        bit hold;
        logic [2:0] init;
        for (int it = 0; it < 10; it++) begin
            for (int k = 0; k < 2; k++) write_w($urandom_range(0, 3), $urandom_range(0, 4));
            init = 3'($urandom_range(0, 7));
            r    = $urandom_range(1, 24);
            mode = $urandom_range(0, 2);
            wa   = $urandom_range(0, 2);
            wd   = $urandom_range(0, 4);
            hold = 1'($urandom_range(0, 1));
            if (mode == 1) mw[wa] = wd;
            do_run(r, init, mode, wa, wd, hold, lat, bcnt);
            model_run(r, init);
            msp = model_spins();
            checks++; if (lat != r + 2) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", it, lat, r + 2); end
            checks++; if (bcnt != r) begin failures++; $display("FAIL rand%0d_busy got=%0d exp=%0d", it, bcnt, r); end
            checks++; if (phase_out !== model_phases()) begin failures++; $display("FAIL rand%0d_phase got=%h exp=%h", it, phase_out, model_phases()); end
            checks++; if (spins_out !== msp) begin failures++; $display("FAIL rand%0d_spins got=%b exp=%b", it, spins_out, msp); end
        end
    endtask

    task automatic test_reset_midrun();
        write_w(0, 0);
        write_w(2, 4);
        @(negedge clk);
        start = 1'b1; run_cycles = 16'd10; init_spins = 3'b101;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        model_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
        checks++; if (phase_out !== 12'h000) begin failures++; $display("FAIL midrst_phase got=%h exp=000", phase_out); end
        checks++; if (spins_out !== 3'b000) begin failures++; $display("FAIL midrst_spins got=%b exp=000", spins_out); end
        @(negedge clk);
        rstn = 1'b1;
        test_default_run("after_rst");
    endtask

    initial begin
        test_reset();
        test_default_run("default");
        test_all_plus2();
        test_write_ignored();
        test_write_with_start();
        test_stop();
        test_r0();
        test_random();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
